// File: rtl/mc_fetch_unit_pkg.sv
// Shared types and constants for the multicycle fetch stage.
package mc_fetch_unit_pkg;

  typedef logic [31:0] u32;
  typedef logic [4:0]  u5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fetch_state_t;

  localparam u32 INSN_NOP = 32'h0000_0000;

  typedef struct packed {
    logic valid;
    u32   addr;
  } ibus_req_t;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic u32 word_align(input u32 addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mc_fetch_unit_timeout_ctr.sv
// WAIT-state timeout counter for mc_fetch_unit; only present when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the LIMIT-th consecutive counting cycle.
  assign expired_o = count_en_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/mc_fetch_unit.sv
// Multicycle fetch stage: one req/ack instruction read per fetch_enable, PC advance and redirect.
// Define FETCH_TIMEOUT_EN to abort stuck fetches after TIMEOUT_CYCLES and report fetch_err_o.
module mc_fetch_unit
  import mc_fetch_unit_pkg::*;
#(
  parameter u32 PC_RESET = 32'hBFC0_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_enable_i,
  input  logic        pc_load_i,
  input  logic [31:0] pc_target_i,
  output logic        ireq_valid_o,
  output logic [31:0] ireq_addr_o,
  input  logic        iresp_ack_i,
  input  logic [31:0] iresp_data_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_busy_o,
  output logic        fetch_done_o
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic        fetch_err_o
`endif
);

  fetch_state_t state_q, state_d;
  u32           pc_q, pc_d;
  u32           insn_q, insn_d;
  u32           pcp4_q, pcp4_d;
  u32           pend_addr_q, pend_addr_d;
  logic         pend_valid_q, pend_valid_d;
  logic         in_flight, ack_hit, timeout_hit, latch;
  ibus_req_t    ireq;

  assign in_flight = (state_q == REQ) || (state_q == WAIT);
  assign ack_hit   = in_flight && iresp_ack_i;
  assign latch     = ack_hit || timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic err_q, err_d;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (state_q != WAIT),
    .count_en_i(state_q == WAIT),
    .expired_o (timeout_hit)
  );

  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && fetch_enable_i) begin
      err_d = 1'b0;
    end else if (timeout_hit && !ack_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign fetch_err_o = err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_enable_i) state_d = REQ;
      REQ:     state_d = iresp_ack_i ? DONE : WAIT;
      WAIT:    if (latch) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ireq.valid   = in_flight;
    ireq.addr    = pc_q;
    fetch_busy_o = in_flight;
    fetch_done_o = (state_q == DONE);
  end

  // Redirects during a fetch are parked so the in-flight address stays stable.
  always_comb begin
    pc_d         = pc_q;
    insn_d       = insn_q;
    pcp4_d       = pcp4_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    if (in_flight) begin
      if (pc_load_i) begin
        pend_addr_d  = word_align(pc_target_i);
        pend_valid_d = 1'b1;
      end
      if (latch) begin
        insn_d       = ack_hit ? iresp_data_i : INSN_NOP;
        pcp4_d       = pc_q + 32'd4;
        pend_valid_d = 1'b0;
        if (pc_load_i) begin
          pc_d = word_align(pc_target_i);
        end else if (pend_valid_q) begin
          pc_d = pend_addr_q;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end else if (pc_load_i) begin
      pc_d = word_align(pc_target_i);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q         <= PC_RESET;
      insn_q       <= INSN_NOP;
      pcp4_q       <= PC_RESET;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      insn_q       <= insn_d;
      pcp4_q       <= pcp4_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign ireq_valid_o  = ireq.valid;
  assign ireq_addr_o   = ireq.addr;
  assign instruction_o = insn_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pcp4_q;

endmodule
